edge_frame_buffer: RTL and testbench
====================================

Name: edge_frame_buffer

Overview:
Double-buffered 1-bit-per-pixel edge map between the edge-detector pixel stream and the vga display stage. Accepts a raster-ordered stream of edge bits (valid/ready with start-of-frame marker) into a back buffer. Serves the display's (hc, vc) lookups from a front buffer. Buffers swap only at a display frame start, so the display never shows a partial frame.

Parameters:
WIDTH, 9, active pixels per line (matches display hpixels)
HEIGHT, 9, active lines per frame (matches display vlines)
CW, 10, width of coordinate/counter fields

Ports:
CLK  input  1  pixel clock, all logic on rising edge
CPU_RESETN  input  1  asynchronous reset, active-high despite name
in_valid  input  1  upstream pixel valid
in_ready  output  1  block can accept pixel this cycle
in_pixel  input  1  edge bit, 1 = edge
in_sof  input  1  marks first pixel of frame, qualified by in_valid
rd_x  input  CW  display column (hc)
rd_y  input  CW  display line (vc)
rd_frame_start  input  1  one-cycle pulse from display at hc=0,vc=0
rd_pixel  output  1  edge bit at (rd_x, rd_y), registered
frame_valid  output  1  front buffer holds a complete frame
sof_err  output  1  sticky: in_sof seen mid-frame

Behaviour:
- Reset (async, CPU_RESETN=1): both buffers cleared to 0; state IDLE; wr_x=wr_y=0; bank select=0; rd_pixel=0, frame_valid=0, sof_err=0; in_ready=1 after reset release.
- Transfer occurs when in_valid && in_ready on a rising edge.
- States:
  - IDLE: in_ready=1. Transfers without in_sof are discarded. Transfer with in_sof writes in_pixel at (0,0), sets wr_x=1, and enters FILL. If WIDTH*HEIGHT==1, it enters DONE instead.
  - FILL: in_ready=1. Each transfer writes back[wr_y*WIDTH+wr_x]. wr_x increments and wraps to 0 at WIDTH-1, incrementing wr_y. The write at (WIDTH-1, HEIGHT-1) enters DONE.
  - DONE: in_ready=0. On rd_frame_start: toggle bank select, set frame_valid=1, clear wr_x/wr_y, go to IDLE.
- In FILL, a transfer with in_sof restarts at (0,0): that pixel is written, wr_x=1, sof_err set (sticky until reset). Stale bits from the aborted frame are overwritten as the new frame fills.
- A DONE entry and an rd_frame_start pulse in the same cycle: no swap that cycle. The swap waits for the next rd_frame_start. Latency from last pixel to display is at most one display frame.
- Read: rd_pixel registered one cycle after rd_x/rd_y. It equals front[rd_y*WIDTH+rd_x] when rd_x<WIDTH and rd_y<HEIGHT, else 0. It is also 0 while frame_valid=0.
- The swap is visible on rd_pixel starting with the read issued in the cycle after the rd_frame_start pulse.
- Address arithmetic: CW-bit operands, 2*CW-bit product, no truncation.
- Buffers are reg arrays of WIDTH*HEIGHT bits each. No read/write port conflict, because reads and writes always target different banks.

Optional Feature:
EDGE_FB_COUNT_EN:
- Defined: adds output edge_count [2*CW-1:0], which holds the number of 1-bits in the front buffer. A back-buffer counter increments on each written 1 (reset to 0 on frame (re)start). It is copied to edge_count at swap. Reset value 0.
- Undefined: port and counter absent; behaviour otherwise identical.

Test Plan:
- Reset then read any (x,y) -> rd_pixel=0, frame_valid=0, in_ready=1.
- Stream 81 pixels of the diagonal pattern (1 where x==y) with in_sof on first, then pulse rd_frame_start -> frame_valid=1; reads at (3,3)=1, (3,4)=0 one cycle later; edge_count=9 when EDGE_FB_COUNT_EN is defined.
- 81 pixels done, no rd_frame_start -> in_ready stays 0; front-buffer reads unchanged; extra in_valid is not accepted.
- in_sof asserted at pixel 40 of a frame -> sof_err=1; the frame completes 81 pixels after the restart; rd_frame_start swaps in the restarted frame.
- Pixels with in_valid but no in_sof in IDLE -> discarded; wr_x stays 0; the next in_sof starts the frame.
- Read at (9,0) and (0,12) -> rd_pixel=0. Assert CPU_RESETN mid-FILL -> all outputs return to reset values immediately.

Source files
------------

// File: rtl/edge_frame_buffer.sv
// Double-buffered 1-bpp edge map: the pixel stream fills the back bank, the display reads the front bank.
// Optional EDGE_FB_COUNT_EN adds edge_count, the number of set bits in the front bank.
module edge_frame_buffer #(
  parameter int WIDTH  = 9,
  parameter int HEIGHT = 9,
  parameter int CW     = 10
) (
  input  logic          CLK,
  input  logic          CPU_RESETN,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_pixel,
  input  logic          in_sof,
  input  logic [CW-1:0] rd_x,
  input  logic [CW-1:0] rd_y,
  input  logic          rd_frame_start,
  output logic          rd_pixel,
  output logic          frame_valid,
`ifdef EDGE_FB_COUNT_EN
  output logic [2*CW-1:0] edge_count,
`endif
  output logic          sof_err
);

  localparam int N  = WIDTH * HEIGHT;
  localparam int AW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] W_C    = CW'(WIDTH);
  localparam logic [CW-1:0] H_C    = CW'(HEIGHT);
  localparam logic [CW-1:0] W_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] H_LAST = CW'(HEIGHT - 1);

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;

  state_t               state_q, state_d;
  logic [CW-1:0]        wr_x_q, wr_x_d, wr_y_q, wr_y_d;
  logic                 sel_q, sel_d;
  logic                 fv_q, fv_d;
  logic                 err_q, err_d;
  logic                 rdy_q, rdy_d;
  logic                 rpix_q, rpix_d;
  logic [1:0][N-1:0]    bank_q, bank_d;
`ifdef EDGE_FB_COUNT_EN
  logic [2*CW-1:0]      cnt_q, cnt_d, ec_q, ec_d;
`endif

  logic                 xfer, wr_en, start;
  logic [CW-1:0]        px, py;
  logic [2*CW-1:0]      waddr, raddr;

  always_comb begin
    state_d = state_q;
    wr_x_d  = wr_x_q;
    wr_y_d  = wr_y_q;
    sel_d   = sel_q;
    fv_d    = fv_q;
    err_d   = err_q;
    bank_d  = bank_q;
`ifdef EDGE_FB_COUNT_EN
    cnt_d   = cnt_q;
    ec_d    = ec_q;
`endif
    xfer    = in_valid && rdy_q;
    wr_en   = 1'b0;
    start   = 1'b0;
    px      = wr_x_q;
    py      = wr_y_q;

    case (state_q)
      IDLE: if (xfer && in_sof) begin
        wr_en   = 1'b1;
        start   = 1'b1;
        state_d = FILL;
      end
      FILL: if (xfer) begin
        wr_en = 1'b1;
        if (in_sof) begin
          start = 1'b1;
          err_d = 1'b1;
        end
      end
      DONE: if (rd_frame_start) begin
        sel_d   = ~sel_q;
        fv_d    = 1'b1;
        wr_x_d  = '0;
        wr_y_d  = '0;
        state_d = IDLE;
`ifdef EDGE_FB_COUNT_EN
        ec_d    = cnt_q;
`endif
      end
      default: state_d = IDLE;
    endcase

    if (start) begin
      px = '0;
      py = '0;
    end
    waddr = {{CW{1'b0}}, py} * {{CW{1'b0}}, W_C} + {{CW{1'b0}}, px};

    // Back bank is always the one the display is not reading.
    if (wr_en) begin
      bank_d[~sel_q][waddr[AW-1:0]] = in_pixel;
`ifdef EDGE_FB_COUNT_EN
      cnt_d = (start ? '0 : cnt_q) + {{(2*CW-1){1'b0}}, in_pixel};
`endif
      if (px == W_LAST && py == H_LAST) begin
        state_d = DONE;
      end else if (px == W_LAST) begin
        wr_x_d = '0;
        wr_y_d = py + CW'(1);
      end else begin
        wr_x_d = px + CW'(1);
        wr_y_d = py;
      end
    end

    rdy_d  = (state_d != DONE);
    raddr  = {{CW{1'b0}}, rd_y} * {{CW{1'b0}}, W_C} + {{CW{1'b0}}, rd_x};
    rpix_d = (fv_q && rd_x < W_C && rd_y < H_C) ? bank_q[sel_q][raddr[AW-1:0]] : 1'b0;
  end

  always_ff @(posedge CLK or posedge CPU_RESETN) begin
    if (CPU_RESETN) begin
      state_q <= IDLE;
      wr_x_q  <= '0;
      wr_y_q  <= '0;
      sel_q   <= 1'b0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      rdy_q   <= 1'b1;
      rpix_q  <= 1'b0;
      bank_q  <= '0;
`ifdef EDGE_FB_COUNT_EN
      cnt_q   <= '0;
      ec_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_x_q  <= wr_x_d;
      wr_y_q  <= wr_y_d;
      sel_q   <= sel_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      rdy_q   <= rdy_d;
      rpix_q  <= rpix_d;
      bank_q  <= bank_d;
`ifdef EDGE_FB_COUNT_EN
      cnt_q   <= cnt_d;
      ec_q    <= ec_d;
`endif
    end
  end

  assign in_ready    = rdy_q;
  assign rd_pixel    = rpix_q;
  assign frame_valid = fv_q;
  assign sof_err     = err_q;
`ifdef EDGE_FB_COUNT_EN
  assign edge_count  = ec_q;
`endif

endmodule

// File: tb/tb_edge_frame_buffer.sv
// Bench for edge_frame_buffer: reset table, directed frame sequences, then random traffic vs a frame-level model.
module tb_edge_frame_buffer;
  localparam int W = 9, H = 9, CW = 10, N = W * H;

  logic          CLK = 1'b0;
  logic          CPU_RESETN;
  logic          in_valid, in_ready, in_pixel, in_sof;
  logic [CW-1:0] rd_x, rd_y;
  logic          rd_frame_start, rd_pixel, frame_valid, sof_err;
`ifdef EDGE_FB_COUNT_EN
  logic [2*CW-1:0] edge_count;
`endif

  edge_frame_buffer #(.WIDTH(W), .HEIGHT(H), .CW(CW)) dut (
    .CLK(CLK), .CPU_RESETN(CPU_RESETN),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel), .in_sof(in_sof),
    .rd_x(rd_x), .rd_y(rd_y), .rd_frame_start(rd_frame_start),
    .rd_pixel(rd_pixel), .frame_valid(frame_valid),
`ifdef EDGE_FB_COUNT_EN
    .edge_count(edge_count),
`endif
    .sof_err(sof_err)
  );

  always #5 CLK = ~CLK;

  int checks = 0, failures = 0;

  // Frame-level model: linear write position, whole-frame copy at swap.
  int m_mode;  // 0 idle, 1 filling, 2 complete and waiting
  int m_pos, m_cnt, m_ec;
  bit m_back[N], m_front[N];
  bit m_fv, m_err, m_rp;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_pos = 0; m_cnt = 0; m_ec = 0;
    m_fv = 0; m_err = 0; m_rp = 0;
    for (int i = 0; i < N; i++) begin m_back[i] = 0; m_front[i] = 0; end
  endtask

  task automatic model_step();
    bit nrp;
    int rx, ry;
    rx = int'(rd_x); ry = int'(rd_y);
    nrp = (m_fv && rx < W && ry < H) ? m_front[ry * W + rx] : 1'b0;
    if (m_mode == 2) begin
      if (rd_frame_start) begin
        m_front = m_back; m_fv = 1; m_ec = m_cnt; m_mode = 0;
      end
    end else if (in_valid) begin
      if (in_sof) begin
        if (m_mode == 1) m_err = 1;
        m_back[0] = in_pixel; m_pos = 1; m_cnt = int'(in_pixel); m_mode = 1;
      end else if (m_mode == 1) begin
        m_back[m_pos] = in_pixel; m_pos++; m_cnt += int'(in_pixel);
      end
      if (m_mode == 1 && m_pos == N) m_mode = 2;
    end
    m_rp = nrp;
  endtask

  task automatic check_all();
    chk("rd_pixel", rd_pixel, m_rp);
    chk("in_ready", in_ready, m_mode != 2);
    chk("frame_valid", frame_valid, m_fv);
    chk("sof_err", sof_err, m_err);
`ifdef EDGE_FB_COUNT_EN
    chk("edge_count", edge_count, m_ec);
`endif
  endtask

  // One clock: drive at negedge, model at posedge, compare at next negedge.
  task automatic cyc(input bit v, input bit p, input bit s, input int x, input int y, input bit fs);
    in_valid = v; in_pixel = p; in_sof = s;
    rd_x = CW'(x); rd_y = CW'(y); rd_frame_start = fs;
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_all();
  endtask

  typedef struct {
    bit v, p, s, fs;
    int x, y;
    bit e_pix, e_rdy, e_fv;
  } vec_t;
  vec_t tbl[6];

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{v:1, p:1, s:0, fs:0, x:0,  y:0,  e_pix:0, e_rdy:1, e_fv:0};
    tbl[1] = '{v:0, p:0, s:0, fs:0, x:3,  y:3,  e_pix:0, e_rdy:1, e_fv:0};
    tbl[2] = '{v:1, p:0, s:0, fs:1, x:9,  y:0,  e_pix:0, e_rdy:1, e_fv:0};
    tbl[3] = '{v:0, p:0, s:0, fs:0, x:0,  y:12, e_pix:0, e_rdy:1, e_fv:0};
    tbl[4] = '{v:1, p:1, s:0, fs:0, x:8,  y:8,  e_pix:0, e_rdy:1, e_fv:0};
    tbl[5] = '{v:0, p:0, s:0, fs:1, x:11, y:11, e_pix:0, e_rdy:1, e_fv:0};

    in_valid = 0; in_pixel = 0; in_sof = 0; rd_x = '0; rd_y = '0; rd_frame_start = 0;
    CPU_RESETN = 1'b1;
    model_reset();
    repeat (2) @(negedge CLK);
    CPU_RESETN = 1'b0;
    check_all();

    // Reset state under reads and non-sof traffic in IDLE
    for (int i = 0; i < 6; i++) begin
      cyc(tbl[i].v, tbl[i].p, tbl[i].s, tbl[i].x, tbl[i].y, tbl[i].fs);
      chk("tbl_pix", rd_pixel, tbl[i].e_pix);
      chk("tbl_ready", in_ready, tbl[i].e_rdy);
      chk("tbl_fv", frame_valid, tbl[i].e_fv);
    end

    // Diagonal frame, stall in DONE, then swap
    for (int i = 0; i < N; i++) cyc(1, (i % W) == (i / W), i == 0, 0, 0, 0);
    chk("diag_done_ready", in_ready, 0);
    repeat (3) cyc(1, 1, 0, 3, 3, 0);
    chk("stall_ready", in_ready, 0);
    chk("stall_fv", frame_valid, 0);
    cyc(0, 0, 0, 3, 3, 1);
    chk("swap_fv", frame_valid, 1);
    cyc(0, 0, 0, 3, 3, 0);
    chk("diag_3_3", rd_pixel, 1);
    cyc(0, 0, 0, 3, 4, 0);
    chk("diag_3_4", rd_pixel, 0);
`ifdef EDGE_FB_COUNT_EN
    chk("diag_count", edge_count, 9);
`endif

    // All-ones frame; front must stay the diagonal until the next swap
    for (int i = 0; i < N; i++) cyc(1, 1, i == 0, 3, 4, 0);
    repeat (4) cyc(1, 0, 0, 3, 4, 0);
    chk("done_front_kept", rd_pixel, 0);
    cyc(0, 0, 0, 3, 4, 1);
    cyc(0, 0, 0, 3, 4, 0);
    chk("ones_3_4", rd_pixel, 1);
`ifdef EDGE_FB_COUNT_EN
    chk("ones_count", edge_count, 81);
`endif

    // in_sof at pixel 40 restarts the frame and sets sticky error
    for (int i = 0; i < 40; i++) cyc(1, 1, i == 0, 0, 0, 0);
    chk("no_err_yet", sof_err, 0);
    for (int i = 0; i < N; i++) begin
      cyc(1, i[0], i == 0, 0, 0, 0);
      if (i == 79) chk("restart_ready_80", in_ready, 1);
    end
    chk("restart_err", sof_err, 1);
    chk("restart_done", in_ready, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("restart_1_0", rd_pixel, 1);
    cyc(0, 0, 0, 0, 0, 0);
    chk("restart_0_0", rd_pixel, 0);

    // Async reset mid-FILL
    for (int i = 0; i < 10; i++) cyc(1, 1, i == 0, 1, 0, 0);
    chk("pre_reset_pix", rd_pixel, 1);
    #2 CPU_RESETN = 1'b1;
    #1;
    model_reset();
    chk("rst_pix", rd_pixel, 0);
    chk("rst_fv", frame_valid, 0);
    chk("rst_err", sof_err, 0);
    chk("rst_ready", in_ready, 1);
`ifdef EDGE_FB_COUNT_EN
    chk("rst_count", edge_count, 0);
`endif
    @(negedge CLK);
    CPU_RESETN = 1'b0;

    // Non-sof traffic in IDLE is dropped; frame then needs exactly N pixels
    repeat (5) cyc(1, 1, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) cyc(1, (i % W) == 0, i == 0, 0, 0, 0);
    chk("idle_done", in_ready, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("col0_0_1", rd_pixel, 1);
    cyc(0, 0, 0, 1, 0, 0);
    chk("col0_1_0", rd_pixel, 0);

    // Random traffic against the model
    for (int c = 0; c < 4000; c++) begin
      bit v, s;
      v = ($urandom_range(0, 9) < 8);
      if (m_mode == 0) s = ($urandom_range(0, 3) == 0);
      else             s = ($urandom_range(0, 999) < 3);
      cyc(v, 1'($urandom_range(0, 1)), s, $urandom_range(0, 11), $urandom_range(0, 11),
          $urandom_range(0, 29) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
